// File: rtl/forwarding_unit.sv
// forwarding_unit: EX-stage operand forwarding selects for the 5-stage RV32 pipeline.
// forward_a/forward_b are purely combinational. The forwarding-event statistics
// counters are only built when FORWARDING_STATS_EN is defined; otherwise
// fwd_ex_cnt/fwd_mem_cnt read constant 0 and clk/rst/cnt_en/cnt_clr are ignored.
// Select encoding: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back data.
module forwarding_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  ex_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic                  mem_wb_regwrite,
  input  logic                  cnt_en,
  input  logic                  cnt_clr,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic [CNT_W-1:0]      fwd_ex_cnt,
  output logic [CNT_W-1:0]      fwd_mem_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  logic w_ex_valid;
  logic w_mem_valid;
  assign w_ex_valid  = ex_mem_regwrite && (ex_mem_rd != '0);
  assign w_mem_valid = mem_wb_regwrite && (mem_wb_rd != '0);

  // Operand A select; EX/MEM wins over MEM/WB since it holds the younger value.
  always_comb begin
    forward_a = SEL_RF;
    if (w_ex_valid && (ex_mem_rd == id_ex_rs1)) begin
      forward_a = SEL_EX;
    end else if (w_mem_valid && (mem_wb_rd == id_ex_rs1)) begin
      forward_a = SEL_MEM;
    end
  end

  // Operand B select, same priority rule evaluated independently of A.
  always_comb begin
    forward_b = SEL_RF;
    if (w_ex_valid && (ex_mem_rd == id_ex_rs2)) begin
      forward_b = SEL_EX;
    end else if (w_mem_valid && (mem_wb_rd == id_ex_rs2)) begin
      forward_b = SEL_MEM;
    end
  end

`ifdef FORWARDING_STATS_EN
  logic [1:0]       w_inc_ex;
  logic [1:0]       w_inc_mem;
  logic [CNT_W:0]   w_sum_ex;
  logic [CNT_W:0]   w_sum_mem;
  logic [CNT_W-1:0] w_next_ex;
  logic [CNT_W-1:0] w_next_mem;
  logic [CNT_W-1:0] r_fwd_ex_cnt;
  logic [CNT_W-1:0] r_fwd_mem_cnt;

  // Per-cycle forward events (0, 1 or 2) and saturating next counter values;
  // the extra sum bit flags overflow so the counter pins at all-ones.
  always_comb begin
    w_inc_ex   = {1'b0, (forward_a == SEL_EX)}  + {1'b0, (forward_b == SEL_EX)};
    w_inc_mem  = {1'b0, (forward_a == SEL_MEM)} + {1'b0, (forward_b == SEL_MEM)};
    w_sum_ex   = {1'b0, r_fwd_ex_cnt}  + {{(CNT_W-1){1'b0}}, w_inc_ex};
    w_sum_mem  = {1'b0, r_fwd_mem_cnt} + {{(CNT_W-1){1'b0}}, w_inc_mem};
    w_next_ex  = w_sum_ex[CNT_W]  ? '1 : w_sum_ex[CNT_W-1:0];
    w_next_mem = w_sum_mem[CNT_W] ? '1 : w_sum_mem[CNT_W-1:0];
  end

  // Statistics counters: async reset, synchronous clear beats counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_ex_cnt  <= '0;
      r_fwd_mem_cnt <= '0;
    end else if (cnt_clr) begin
      r_fwd_ex_cnt  <= '0;
      r_fwd_mem_cnt <= '0;
    end else if (cnt_en) begin
      r_fwd_ex_cnt  <= w_next_ex;
      r_fwd_mem_cnt <= w_next_mem;
    end
  end

  assign fwd_ex_cnt  = r_fwd_ex_cnt;
  assign fwd_mem_cnt = r_fwd_mem_cnt;
`else
  // Counters not built: the clocking/control inputs are deliberately unused.
  logic w_unused;
  assign w_unused    = ^{clk, rst, cnt_en, cnt_clr};
  assign fwd_ex_cnt  = '0;
  assign fwd_mem_cnt = '0;
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: vector table for the combinational selects plus clocked
// sequences for the statistics counters (expected zero when the counters are not built).
module tb_forwarding_unit;

  localparam int RW = 5;
  localparam int CW = 4;
`ifdef FORWARDING_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_ex_rs1, id_ex_rs2, ex_mem_rd, mem_wb_rd;
  logic          ex_mem_regwrite, mem_wb_regwrite;
  logic          cnt_en, cnt_clr;
  logic [1:0]    forward_a, forward_b;
  logic [CW-1:0] fwd_ex_cnt, fwd_mem_cnt;

  int errors = 0;
  int checks = 0;

  forwarding_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .forward_a(forward_a), .forward_b(forward_b),
    .fwd_ex_cnt(fwd_ex_cnt), .fwd_mem_cnt(fwd_mem_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rs1, rs2, exrd;
    logic          exwe;
    logic [RW-1:0] wbrd;
    logic          wbwe;
    logic [1:0]    ea, eb;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cexp(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic set_ops(input int rs1, input int rs2, input int exrd, input bit exwe,
                         input int wbrd, input bit wbwe);
    id_ex_rs1 = RW'(rs1); id_ex_rs2 = RW'(rs2);
    ex_mem_rd = RW'(exrd); ex_mem_regwrite = exwe;
    mem_wb_rd = RW'(wbrd); mem_wb_regwrite = wbwe;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name, input int ex, input int mem);
    chk({name, " ex_cnt"},  int'(fwd_ex_cnt),  cexp(ex));
    chk({name, " mem_cnt"}, int'(fwd_mem_cnt), cexp(mem));
  endtask

  initial begin
    //          rs1 rs2 exrd exwe wbrd wbwe  a     b
    vecs[0]  = '{1,  2,  4,  1,   5,   1,   2'b00, 2'b00};
    vecs[1]  = '{1,  2,  2,  1,   5,   1,   2'b00, 2'b01};
    vecs[2]  = '{2,  1,  2,  1,   5,   1,   2'b01, 2'b00};
    vecs[3]  = '{2,  1,  4,  0,   2,   1,   2'b10, 2'b00};
    vecs[4]  = '{1,  2,  4,  0,   2,   1,   2'b00, 2'b10};
    vecs[5]  = '{2,  1,  2,  1,   2,   1,   2'b01, 2'b00};
    vecs[6]  = '{0,  0,  0,  1,   0,   1,   2'b00, 2'b00};
    vecs[7]  = '{2,  3,  2,  0,   3,   0,   2'b00, 2'b00};
    vecs[8]  = '{2,  3,  3,  1,   2,   1,   2'b10, 2'b01};
    vecs[9]  = '{5,  5,  5,  1,   5,   1,   2'b01, 2'b01};
    vecs[10] = '{7,  7,  9,  1,   7,   1,   2'b10, 2'b10};
    vecs[11] = '{31, 31, 31, 1,   31,  0,   2'b01, 2'b01};
    vecs[12] = '{0,  3,  0,  1,   3,   1,   2'b00, 2'b10};
    vecs[13] = '{4,  6,  4,  0,   4,   0,   2'b00, 2'b00};

    rst = 1'b1; cnt_en = 1'b0; cnt_clr = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0);
    #12;
    chk_cnt("reset", 0, 0);

    // Combinational table, applied while rst is still asserted to show independence.
    for (int i = 0; i < NV; i++) begin
      set_ops(vecs[i].rs1, vecs[i].rs2, vecs[i].exrd, vecs[i].exwe, vecs[i].wbrd, vecs[i].wbwe);
      #1;
      chk($sformatf("vec%0d fwd_a", i), int'(forward_a), int'(vecs[i].ea));
      chk($sformatf("vec%0d fwd_b", i), int'(forward_b), int'(vecs[i].eb));
    end

    // Counters: release reset just after an edge.
    @(posedge clk); #1;
    rst = 1'b0;
    chk_cnt("after_release", 0, 0);

    set_ops(2, 2, 2, 1, 0, 0);
    cnt_en = 1'b1;
    repeat (3) tick();
    chk_cnt("ex_x3", 6, 0);

    cnt_en = 1'b0;
    tick();
    chk_cnt("hold", 6, 0);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk_cnt("clear", 0, 0);

    cnt_en = 1'b1;
    set_ops(2, 1, 4, 0, 2, 1);
    tick();
    chk_cnt("mem_a", 0, 1);
    set_ops(2, 2, 4, 0, 2, 1);
    tick();
    chk_cnt("mem_ab", 0, 3);
    set_ops(2, 3, 3, 1, 2, 1);
    tick();
    chk_cnt("mixed", 1, 4);
    set_ops(0, 0, 0, 1, 0, 1);
    tick();
    chk_cnt("x0_no_count", 1, 4);

    cnt_clr = 1'b1;
    set_ops(2, 2, 2, 1, 0, 0);
    tick();
    cnt_clr = 1'b0;
    chk_cnt("clr_priority", 0, 0);

    repeat (7) tick();
    chk_cnt("near_max", 14, 0);
    tick();
    chk_cnt("sat_step", 15, 0);
    tick();
    chk_cnt("sat_hold", 15, 0);

    // Async reset mid-cycle: counters clear at once, selects untouched.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    tick();
    chk_cnt("pre_rst", 2, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_cnt("async_rst", 0, 0);
    chk("rst fwd_a", int'(forward_a), 1);
    chk("rst fwd_b", int'(forward_b), 1);
    #4;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
